// File: rtl/seg_scan_driver.sv
// Six-digit time-multiplexed seven-segment scan driver with per-frame input snapshot.
// Define SCAN_BLANK_EN to insert a BLANK_CYCLES all-off guard at the start of every digit slot.
module seg_scan_driver #(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_state,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  input  logic [7:0] d3,
  input  logic [7:0] d4,
  input  logic [7:0] d5,
  output logic [7:0] seg_out,
  output logic [5:0] dig_sel,
  output logic       frame_tick
);

  localparam int unsigned CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_CYCLES - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
`endif

  if (BLANK_CYCLES < 1 || DIGIT_CYCLES <= BLANK_CYCLES) begin : g_cfg_check
    $error("seg_scan_driver: need DIGIT_CYCLES > BLANK_CYCLES >= 1");
  end

  typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;

  state_t          state_q;
  logic [2:0]      idx_q;
  logic [2:0]      idx_d;
  logic            wrap_d;
  logic [CW-1:0]   cnt_q;
  logic [5:0][7:0] shadow_q;
  logic [5:0][7:0] d_in;

  assign d_in = {d5, d4, d3, d2, d1, d0};

  always_comb begin
    wrap_d = (idx_q == 3'd5);
    idx_d  = wrap_d ? 3'd0 : idx_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= OFF;
      idx_q      <= 3'd0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      seg_out    <= 8'h00;
      dig_sel    <= 6'b000000;
      frame_tick <= 1'b0;
    end else if (!power_state) begin
      // Power loss aborts the slot immediately; shadows are refreshed on power-up anyway.
      state_q    <= OFF;
      idx_q      <= 3'd0;
      cnt_q      <= '0;
      seg_out    <= 8'h00;
      dig_sel    <= 6'b000000;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      case (state_q)
        OFF: begin
          idx_q      <= 3'd0;
          cnt_q      <= '0;
          shadow_q   <= d_in;
          frame_tick <= 1'b1;
`ifdef SCAN_BLANK_EN
          state_q    <= BLANK;
          seg_out    <= 8'h00;
          dig_sel    <= 6'b000000;
`else
          state_q    <= SHOW;
          seg_out    <= d0;
          dig_sel    <= 6'b000001;
`endif
        end
`ifdef SCAN_BLANK_EN
        BLANK: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == BLANK_LAST) begin
            state_q <= SHOW;
            seg_out <= shadow_q[idx_q];
            dig_sel <= 6'b000001 << idx_q;
          end
        end
`endif
        SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            cnt_q <= '0;
            idx_q <= idx_d;
            if (wrap_d) begin
              shadow_q   <= d_in;
              frame_tick <= 1'b1;
            end
`ifdef SCAN_BLANK_EN
            state_q <= BLANK;
            seg_out <= 8'h00;
            dig_sel <= 6'b000000;
`else
            // The wrap slot must show the fresh snapshot, not the stale shadow.
            seg_out <= wrap_d ? d0 : shadow_q[idx_d];
            dig_sel <= 6'b000001 << idx_d;
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= OFF;
          seg_out <= 8'h00;
          dig_sel <= 6'b000000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGIT_CYCLES=8, BLANK_CYCLES=2; follows SCAN_BLANK_EN.
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       power_state;
  logic [7:0] d0, d1, d2, d3, d4, d5;
  logic [7:0] seg_out;
  logic [5:0] dig_sel;
  logic       frame_tick;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .power_state(power_state),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
    .seg_out(seg_out), .dig_sel(dig_sel), .frame_tick(frame_tick)
  );

`ifdef SCAN_BLANK_EN
  localparam int G = 2;
`else
  localparam int G = 0;
`endif

  int         total = 0;
  int         bad = 0;
  int         k = 0;
  bit         on = 1'b0;
  logic [7:0] exp_sh [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // One clock: snapshot expectation at frame start, then check all outputs mid-cycle.
  task automatic cyc();
    int         slot, pos;
    logic [5:0] ed;
    logic [7:0] es;
    logic       et;
    if (on && (k % 48 == 0)) exp_sh = '{d0, d1, d2, d3, d4, d5};
    @(posedge clk);
    @(negedge clk);
    ed = 6'b0; es = 8'h00; et = 1'b0;
    if (on) begin
      slot = (k / 8) % 6;
      pos  = k % 8;
      et   = (k % 48 == 0);
      if (pos >= G) begin
        ed = 6'b000001 << slot;
        es = exp_sh[slot];
      end
    end
    chk("seg_out", {24'h0, seg_out}, {24'h0, es});
    chk("dig_sel", {26'h0, dig_sel}, {26'h0, ed});
    chk("frame_tick", {31'h0, frame_tick}, {31'h0, et});
    if (on) k++;
  endtask

  initial begin
    reset = 1'b0; power_state = 1'b1;
    d0 = 8'h3F; d1 = 8'h06; d2 = 8'h66; d3 = 8'h5B; d4 = 8'h6D; d5 = 8'h7D;
    @(negedge clk);
    repeat (5) cyc();

    // Release reset: first frame, change d3 during digit 1's slot.
    reset = 1'b1; on = 1'b1; k = 0;
    repeat (10) cyc();
    d3 = 8'h4F;
    repeat (70) cyc();

    // Into frame 2, drop power mid-SHOW of digit 2.
    repeat (35) cyc();
    power_state = 1'b0; on = 1'b0;
    repeat (3) cyc();
    power_state = 1'b1; on = 1'b1; k = 0;
    repeat (36) cyc();

    // One-cycle reset mid-SHOW of digit 4.
    reset = 1'b0; on = 1'b0;
    cyc();
    reset = 1'b1; on = 1'b1; k = 0;
    repeat (56) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed seven-segment scan driver for the range-hood console. It sits directly downstream of the timer's six per-digit segment patterns (hour, minute, second; two digits each). It drives one shared 8-bit segment bus plus a one-hot digit select, cycling through the six digits. Each frame is shown from a coherent snapshot, and the display is blanked whenever the hood is powered off.

## Interface
Parameters:
- DIGIT_CYCLES, 100000: clock cycles per digit slot (1 ms at 100 MHz); must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 2000: anti-ghosting guard cycles at the start of each slot; must be ≥1. Used only with SCAN_BLANK_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- power_state  in  1  hood power status; 0 blanks the display.
- d0..d5  in  8 each  segment patterns: d0/d1 hour tens/units, d2/d3 minute, d4/d5 second; bit=1 means segment lit.
- seg_out  out  8  shared segment bus, active-high.
- dig_sel  out  6  one-hot digit enable, active-high; bit i selects d_i.
- frame_tick  out  1  one-cycle pulse on each shadow-register load.

## Operation
- All outputs are registered. Reset values: seg_out=8'h00, dig_sel=6'b000000, frame_tick=0.
- Internal state: state register (OFF, BLANK, SHOW), 3-bit digit index (0..5), slot counter of width $clog2(DIGIT_CYCLES), and six 8-bit shadow registers.
- Reset (reset==0 at an edge): state=OFF, index=0, counter=0, shadows=0. Reset overrides every other input.
- OFF:
  - Outputs are zero and counters are held at 0.
  - On the first edge with power_state==1, move to BLANK (or to SHOW without the macro) with index=0.
  - On that same edge, load the shadows from d0..d5 and pulse frame_tick.
- BLANK:
  - dig_sel=0 and seg_out=0 for BLANK_CYCLES cycles.
  - Then move to SHOW with the same index.
- SHOW:
  - dig_sel=one-hot(index) and seg_out=shadow[index].
  - Lasts DIGIT_CYCLES−BLANK_CYCLES cycles (DIGIT_CYCLES cycles without the macro).
  - Then index=(index+1) mod 6 and return to BLANK, or start the next SHOW slot directly without the macro.
- Index wrap 5→0: on the same edge, reload the shadows from d0..d5 and pulse frame_tick for one cycle.
- Input changes are never visible mid-frame; they appear only in the next frame.
- power_state==0 in any state: the next edge moves to OFF. Outputs are zero from that cycle on, and index and counter are cleared. Power-up therefore always restarts at digit 0 with a fresh snapshot.
- dig_sel is never multi-hot. seg_out is 0 whenever dig_sel is 0.

## Timing
- Slot length is exactly DIGIT_CYCLES cycles in both configurations. A frame is 6×DIGIT_CYCLES cycles, and frame_tick has period 6×DIGIT_CYCLES while powered.
- Latency:
  - Edge at which OFF sees power_state==1 → frame_tick high in the following cycle.
  - With the macro, dig_sel=6'b000001 first appears BLANK_CYCLES cycles after that.
  - Without the macro, dig_sel=6'b000001 appears in the same cycle as frame_tick.
- power_state fall → outputs zero one cycle later. There is no partial-slot completion.

## Configuration
- SCAN_BLANK_EN defined: BLANK state is compiled in. Each slot is BLANK_CYCLES of all-zero outputs followed by DIGIT_CYCLES−BLANK_CYCLES of display.
- SCAN_BLANK_EN undefined: BLANK state and BLANK_CYCLES are unused. Slots are back-to-back, and dig_sel moves directly from one digit to the next with no zero gap.

## Test plan
Bench parameters: DIGIT_CYCLES=8, BLANK_CYCLES=2.
- Hold reset=0 for 5 cycles with power_state=1 and d0..d5 nonzero → seg_out=0, dig_sel=0, frame_tick=0 throughout.
- Release reset with d0=8'h3F, d1=8'h06 (macro on):
  - frame_tick pulses once.
  - 2 zero cycles, then dig_sel=000001 with seg_out=3F for 6 cycles.
  - 2 zero cycles, then dig_sel=000010 with seg_out=06.
  - frame_tick repeats every 48 cycles.
- Change d3 from 8'h5B to 8'h4F during digit 1's slot → digit 3 still shows 5B this frame and shows 4F from the next frame on.
- Drop power_state during digit 2 SHOW → all outputs zero on the next cycle. Raise it again → frame_tick pulses and the scan restarts at digit 0 with a blank guard.
- Assert reset for 1 cycle mid-SHOW of digit 4 → outputs zero on the next cycle. After release, the scan restarts at digit 0.
- Build without SCAN_BLANK_EN → each digit is held for exactly 8 cycles, dig_sel is never 0 while powered, and the sequence is 000001→000010→…→100000→000001.
